// File: rtl/font_rom_arbiter_if.sv
// Requester-side bus of the font ROM arbiter: per-requester request/address,
// combinational one-hot grant, and the routed response (one-hot valid plus
// the shared data bus).
interface font_rom_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 3
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;

   modport master (
      output req, req_addr,
      input  gnt, rsp_valid, rsp_data
   );

   modport slave (
      input  req, req_addr,
      output gnt, rsp_valid, rsp_data
   );
endinterface

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one registered-read font ROM between NUM_REQ glyph
// fetchers. One grant per clock, response two cycles after the grant, always
// returned in grant order.
// Build option: FONT_ARB_FIXED_PRIORITY_EN selects fixed priority (lowest
// index wins, no rotation pointer); default is round-robin.
module font_rom_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   font_rom_arbiter_if.slave bus,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] gnt_c;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic [ADDR_W-1:0]  addr_c;
   logic               tag1_v;
   logic [IDX_W-1:0]   tag1_idx;
   logic [NUM_REQ-1:0] rsp_valid_q;

`ifdef FONT_ARB_FIXED_PRIORITY_EN
   // Fixed priority pick: lowest requesting index wins; held off during reset.
   always_comb begin
      gnt_c   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && bus.req[i]) begin
               gnt_any  = 1'b1;
               gnt_c[i] = 1'b1;
               gnt_idx  = IDX_W'(i);
            end
         end
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr;

   // Round-robin pick: first pass covers indices at/above rr_ptr, second pass
   // wraps around to the low indices.
   always_comb begin
      gnt_c   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && bus.req[i] && (IDX_W'(i) >= rr_ptr)) begin
               gnt_any  = 1'b1;
               gnt_c[i] = 1'b1;
               gnt_idx  = IDX_W'(i);
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && bus.req[i]) begin
               gnt_any  = 1'b1;
               gnt_c[i] = 1'b1;
               gnt_idx  = IDX_W'(i);
            end
         end
      end
   end

   // Pointer moves just past the winner; held when nobody is granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end
`endif

   // Address mux driven by the one-hot grant.
   always_comb begin
      addr_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_c[i]) addr_c = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
   end

   // Issue/return pipeline: stage 1 tags the ROM access, stage 2 is the
   // one-hot valid aligned with the ROM's registered output.
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr    <= '0;
         tag1_v      <= 1'b0;
         tag1_idx    <= '0;
         rsp_valid_q <= '0;
      end else begin
         if (gnt_any) rom_addr <= addr_c;
         tag1_v      <= gnt_any;
         tag1_idx    <= gnt_idx;
         rsp_valid_q <= tag1_v ? (NUM_REQ'(1) << tag1_idx) : '0;
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rom_data;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter with a registered-read ROM model.
module tb_font_rom_arbiter;
   localparam int N  = 3;
   localparam int AW = 6;
   localparam int DW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   int            total = 0;
   int            bad   = 0;
   logic [AW-1:0] addr3 [3];

   font_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   font_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .rom_addr (rom_addr),
      .rom_data (rom_data)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
      int v;
      v = int'(a) * 5 + 3 + int'(a) / 8;
      return v[DW-1:0];
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [N-1:0] r);
      bus.req = r;
      #1;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      bus.req_addr[i*AW +: AW] = a;
   endtask

   initial begin
      logic [N-1:0] exp_g;
      int la, g;
      addr3[0] = 6'd5;
      addr3[1] = 6'd9;
      addr3[2] = 6'd13;
      // 1: reset held two cycles with all requests up
      reset = 1'b1;
      bus.req = 3'b111;
      for (int i = 0; i < N; i++) set_addr(i, addr3[i]);
      tick();
      chk("rst_gnt0", bus.gnt, 0);
      chk("rst_valid0", bus.rsp_valid, 0);
      chk("rst_addr0", rom_addr, 0);
      tick();
      chk("rst_gnt1", bus.gnt, 0);
      chk("rst_valid1", bus.rsp_valid, 0);
      chk("rst_addr1", rom_addr, 0);
      reset = 1'b0;
      set_req(3'b000);
      chk("post_rst_gnt", bus.gnt, 0);
      tick();
      chk("post_rst_addr", rom_addr, 0);
      chk("post_rst_valid", bus.rsp_valid, 0);

      // 2: single read from requester 1
      set_addr(1, 6'd17);
      set_req(3'b010);
      chk("single_gnt", bus.gnt, 3'b010);
      tick();
      set_req(3'b000);
      chk("single_addr", rom_addr, 17);
      chk("single_valid_early", bus.rsp_valid, 0);
      tick();
      chk("single_valid", bus.rsp_valid, 3'b010);
      chk("single_data", bus.rsp_data, rom_fn(6'd17));
      set_addr(1, addr3[1]);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // 3: round-robin with all three requesting for six cycles
      for (int c = 0; c < 9; c++) begin
         tick();
         set_req(c < 6 ? 3'b111 : 3'b000);
         exp_g = (c < 6) ? (3'b001 << (c % 3)) : 3'b000;
         chk("rr_gnt", bus.gnt, exp_g);
         if (c >= 1) begin
            la = (c - 1 < 5) ? c - 1 : 5;
            chk("rr_addr", rom_addr, addr3[la % 3]);
         end
         if (c >= 2) begin
            g = c - 2;
            if (g < 6) begin
               chk("rr_valid", bus.rsp_valid, 3'b001 << (g % 3));
               chk("rr_data", bus.rsp_data, rom_fn(addr3[g % 3]));
            end else begin
               chk("rr_valid_idle", bus.rsp_valid, 0);
            end
         end
      end

      // 4: wrap from rr_ptr=2 with requesters 0 and 1
      tick();
      set_req(3'b010);
      chk("wrap_setup", bus.gnt, 3'b010);
      tick();
      set_req(3'b011);
      chk("wrap_first", bus.gnt, 3'b001);
      tick();
      set_req(3'b010);
      chk("wrap_second", bus.gnt, 3'b010);
      tick();
      set_req(3'b111);
      chk("wrap_ptr2", bus.gnt, 3'b100);
      tick();
      set_req(3'b000);
      tick();
      tick();

      // 5: reset one cycle after a grant
      tick();
      set_req(3'b001);
      chk("mid_gnt", bus.gnt, 3'b001);
      tick();
      reset = 1'b1;
      set_req(3'b111);
      chk("mid_gnt_forced", bus.gnt, 0);
      tick();
      reset = 1'b0;
      set_req(3'b101);
      chk("mid_valid_t2", bus.rsp_valid, 0);
      chk("mid_addr", rom_addr, 0);
      chk("mid_ptr0", bus.gnt, 3'b001);
      tick();
      set_req(3'b000);
      chk("mid_valid_t3", bus.rsp_valid, 0);
      tick();
      chk("mid_after_valid", bus.rsp_valid, 3'b001);
      chk("mid_after_data", bus.rsp_data, rom_fn(addr3[0]));

      // 6: requesters 0 and 2 held for four cycles
      for (int c = 0; c < 4; c++) begin
         tick();
         set_req(3'b101);
`ifdef FONT_ARB_FIXED_PRIORITY_EN
         exp_g = 3'b001;
`else
         exp_g = (c % 2 == 0) ? 3'b100 : 3'b001;
`endif
         chk("pri_gnt", bus.gnt, exp_g);
      end
      tick();
      set_req(3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
